mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the data path's Read/Write memory interface. It accepts single-cycle Read or Write strobes addressed by the MAR value. It returns read data on `Mdatain` for capture into the MDR, or commits MDR data to storage. Each transaction completes after a fixed, parameterised latency and is signalled by a one-cycle `MemReady` pulse. It is the memory-side counterpart of the control sequencing that drives `Read`/`MDRin`, and it replaces the stimulus-driven `Mdatain` in system-level benches.

## Interface
- `ADDR_W`, 9: word-address width; storage depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 2: cycles from request-sampling edge to `MemReady`. Legal range is 1..15.
- `Clock`  in  1  system clock; all state updates on its rising edge.
- `clear`  in  1  reset, synchronous and active-low.
- `Read`  in  1  read request strobe, sampled only in IDLE.
- `Write`  in  1  write request strobe, sampled only in IDLE.
- `MARaddr`  in  32  address from MAR; bits [ADDR_W-1:0] index storage.
- `mdrData`  in  32  write data from MDR, captured at accept.
- `Mdatain`  out  32  read data to the MDR input mux, registered.
- `MemReady`  out  1  one-cycle completion pulse, for both read and write.
- `Busy`  out  1  high while a transaction is in flight.
- `AddrErr`  out  1  out-of-range flag; exists only with `MEM_ADDR_CHECK_EN` (see Configuration).

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - On a rising edge with `Read|Write` high, capture `MARaddr`, `mdrData` and the operation type (`op_wr = Write`).
  - If `LATENCY==1`, go to RESP. Otherwise load the wait counter with `LATENCY-2` and go to WAIT.
- **WAIT:** decrement the counter each cycle; when it reaches 0, go to RESP.
- **RESP** (one cycle):
  - Read: `Mdatain <= mem[addr]`.
  - Write: `mem[addr] <= data`; `Mdatain` is unchanged.
  - `MemReady=1`, then return to IDLE.
- **Priority:** `Read` and `Write` both high at accept → write performed, read discarded, `Mdatain` unchanged.
- **Requests while Busy:** strobes in WAIT or RESP are ignored. They are not queued and raise no error.
- **Held strobes:** a strobe still high in the IDLE cycle after RESP starts a new transaction. Requesters drive strobes for exactly one cycle.
- **`Mdatain` persistence:** holds the last completed read value until the next read completes.
- **Address width:** address bits above ADDR_W-1 are ignored (the address aliases), unless `MEM_ADDR_CHECK_EN` is defined.
- **Reset:**
  - `clear=0` at a rising edge forces IDLE, `Mdatain=0`, `MemReady=0`, `Busy=0`, `AddrErr=0`, wait counter 0.
  - Storage contents are not cleared.
  - Reset mid-transaction drops the transaction; a write not yet in RESP is never committed.

## Timing
- Request sampled at edge N → `Busy` high from edge N through the RESP cycle, low after edge N+LATENCY.
- `MemReady` and the new `Mdatain` are both registered, high/valid after edge N+LATENCY for exactly one cycle. The requester captures `Mdatain` into the MDR (`MDRin`) at edge N+LATENCY+1.
- Throughput: the earliest next accept is edge N+LATENCY+1, so one transaction per LATENCY+1 cycles.
- Storage write occurs at edge N+LATENCY. A read issued at the following accept returns the new value.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- **`MEM_ADDR_CHECK_EN` defined:**
  - At accept, `MARaddr[31:ADDR_W] != 0` marks the transaction as erroneous.
  - It still completes with normal latency; `AddrErr` pulses high together with `MemReady`.
  - Read returns `Mdatain=32'h0`; write is suppressed.
- **Not defined:** the `AddrErr` port and its logic are absent and upper address bits alias silently.

## Test plan
- **Write/read:** write `mdrData=32'hFFFFFFF4` (−12) to address 5, then read address 5 → `MemReady` pulses LATENCY cycles after each strobe and `Mdatain=32'hFFFFFFF4` after the read's pulse.
- **Latency sweep:** with LATENCY=1, 2 and 7, a single-cycle `Read` at edge N → `MemReady` exactly at N+LATENCY, single cycle; `Busy` spans the same interval.
- **Simultaneous strobes:** `Read=Write=1`, address 3, data `32'h12` → `mem[3]=32'h12` and `Mdatain` keeps its prior value. A subsequent read of address 3 returns `32'h12`.
- **Busy requests:** a `Read` to address 9 asserted during WAIT of a read to address 5 → ignored; exactly one `MemReady` and `Mdatain=mem[5]`.
- **Reset mid-write:** `clear=0` during WAIT of a write of `32'hDEADBEEF` to address 7 → all outputs 0 on the next cycle and `mem[7]` unchanged.
- **Address check:** with `MEM_ADDR_CHECK_EN`, read `MARaddr=32'h0000_0205` (ADDR_W=9) → `AddrErr` and `MemReady` high together, `Mdatain=0`. Without the macro, the same read returns `mem[5]`.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts Read/Write strobes in IDLE and answers after LATENCY cycles.
// Optional out-of-range address flag is enabled by defining MEM_ADDR_CHECK_EN.
module mem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] MARaddr,
  input  logic [31:0] mdrData,
  output logic [31:0] Mdatain,
  output logic        MemReady,
  output logic        Busy
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic        AddrErr
`endif
);

  localparam int DATA_W = 32;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              resp;

  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              op_wr_p0;
  logic              err_p0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Read || Write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture at accept; write wins when both strobes are high
  always_ff @(posedge Clock) begin
    if (accept) begin
      addr_p0  <= MARaddr[ADDR_W-1:0];
      data_p0  <= mdrData;
      op_wr_p0 <= Write;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge Clock) begin
    if (accept) err_p0 <= |MARaddr[31:ADDR_W];
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^MARaddr[31:ADDR_W];
  assign err_p0         = 1'b0;
`endif

  // Storage is never reset; commit happens only on the RESP edge
  always_ff @(posedge Clock) begin
    if (clear && resp && op_wr_p0 && !err_p0) mem[addr_p0] <= data_p0;
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      Mdatain  <= '0;
      MemReady <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      MemReady <= resp;
      Busy     <= (state_d != IDLE);
      if (resp && !op_wr_p0) Mdatain <= err_p0 ? '0 : mem[addr_p0];
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge Clock) begin
    if (!clear) AddrErr <= 1'b0;
    else        AddrErr <= resp && err_p0;
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: main instance at LATENCY=2, plus LATENCY=1 and 7 for the timing sweep.
module tb_mem_responder;

  logic        Clock;
  logic        clear;
  logic        Read, Write;
  logic [31:0] MARaddr, mdrData;
  logic [31:0] Mdatain;
  logic        MemReady, Busy;
  logic        r1, r7;
  logic [31:0] md1, md7;
  logic        mr1, mr7, b1, b7;
`ifdef MEM_ADDR_CHECK_EN
  logic        AddrErr, ae1, ae7;
`endif

  int ntests = 0;
  int nfail  = 0;

  mem_responder #(.ADDR_W(9), .LATENCY(2)) dut (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write),
    .MARaddr(MARaddr), .mdrData(mdrData),
    .Mdatain(Mdatain), .MemReady(MemReady), .Busy(Busy)
`ifdef MEM_ADDR_CHECK_EN
    , .AddrErr(AddrErr)
`endif
  );

  mem_responder #(.ADDR_W(9), .LATENCY(1)) dut1 (
    .Clock(Clock), .clear(clear), .Read(r1), .Write(1'b0),
    .MARaddr(32'd0), .mdrData(32'd0),
    .Mdatain(md1), .MemReady(mr1), .Busy(b1)
`ifdef MEM_ADDR_CHECK_EN
    , .AddrErr(ae1)
`endif
  );

  mem_responder #(.ADDR_W(9), .LATENCY(7)) dut7 (
    .Clock(Clock), .clear(clear), .Read(r7), .Write(1'b0),
    .MARaddr(32'd0), .mdrData(32'd0),
    .Mdatain(md7), .MemReady(mr7), .Busy(b7)
`ifdef MEM_ADDR_CHECK_EN
    , .AddrErr(ae7)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request; returns just after the accepting edge
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    Read    = rd;
    Write   = wr;
    MARaddr = addr;
    mdrData = data;
    tick();
    Read  = 1'b0;
    Write = 1'b0;
  endtask

  initial begin
    clear = 1'b0; Read = 1'b0; Write = 1'b0; MARaddr = '0; mdrData = '0;
    r1 = 1'b0; r7 = 1'b0;
    tick(); tick();
    chk("rst_mdatain", Mdatain, 32'h0);
    chk("rst_ready", {31'd0, MemReady}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_busy7", {31'd0, b7}, 32'd0);
`ifdef MEM_ADDR_CHECK_EN
    chk("rst_addrerr", {31'd0, AddrErr}, 32'd0);
`endif
    clear = 1'b1;

    // Write -12 to address 5 and track the timing edge by edge
    req(1'b0, 1'b1, 32'd5, 32'hFFFF_FFF4);
    chk("wr_busy_n0", {31'd0, Busy}, 32'd1);
    chk("wr_ready_n0", {31'd0, MemReady}, 32'd0);
    tick();
    chk("wr_busy_n1", {31'd0, Busy}, 32'd1);
    chk("wr_ready_n1", {31'd0, MemReady}, 32'd0);
    tick();
    chk("wr_ready_n2", {31'd0, MemReady}, 32'd1);
    chk("wr_busy_n2", {31'd0, Busy}, 32'd0);
    chk("wr_mdatain_kept", Mdatain, 32'h0);
    tick();
    chk("wr_ready_n3", {31'd0, MemReady}, 32'd0);

    // Seed addresses 9 and 7 with distinct values
    req(1'b0, 1'b1, 32'd9, 32'h0000_0099); tick(); tick(); tick();
    req(1'b0, 1'b1, 32'd7, 32'h0000_0077); tick(); tick(); tick();

    req(1'b1, 1'b0, 32'd5, 32'h0);
    tick(); tick();
    chk("rd5_ready", {31'd0, MemReady}, 32'd1);
    chk("rd5_data", Mdatain, 32'hFFFF_FFF4);
    tick();
    chk("rd5_ready_drop", {31'd0, MemReady}, 32'd0);
    chk("rd5_persist", Mdatain, 32'hFFFF_FFF4);

    // Both strobes: write wins, read data untouched
    req(1'b1, 1'b1, 32'd3, 32'h0000_0012);
    tick(); tick();
    chk("rw_ready", {31'd0, MemReady}, 32'd1);
    chk("rw_mdatain_kept", Mdatain, 32'hFFFF_FFF4);
    tick();
    req(1'b1, 1'b0, 32'd3, 32'h0);
    tick(); tick();
    chk("rd3_data", Mdatain, 32'h0000_0012);
    tick();

    // Read of 9 issued during WAIT of a read of 5 is ignored
    req(1'b1, 1'b0, 32'd5, 32'h0);
    Read = 1'b1; MARaddr = 32'd9;
    tick();
    Read = 1'b0;
    tick();
    chk("busyreq_ready", {31'd0, MemReady}, 32'd1);
    chk("busyreq_data", Mdatain, 32'hFFFF_FFF4);
    tick();
    chk("busyreq_ready_drop", {31'd0, MemReady}, 32'd0);
    chk("busyreq_idle", {31'd0, Busy}, 32'd0);
    tick();
    chk("busyreq_no_second", {31'd0, MemReady}, 32'd0);

    // Reset during WAIT of a write drops it
    req(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
    clear = 1'b0;
    tick();
    chk("midrst_mdatain", Mdatain, 32'h0);
    chk("midrst_ready", {31'd0, MemReady}, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    clear = 1'b1;
    tick();
    chk("midrst_no_ready", {31'd0, MemReady}, 32'd0);
    req(1'b1, 1'b0, 32'd7, 32'h0);
    tick(); tick();
    chk("rd7_unchanged", Mdatain, 32'h0000_0077);
    tick();

    // Upper address bits: flagged with the check, aliased without it
    req(1'b1, 1'b0, 32'h0000_0205, 32'h0);
    tick(); tick();
    chk("hiaddr_ready", {31'd0, MemReady}, 32'd1);
`ifdef MEM_ADDR_CHECK_EN
    chk("hiaddr_err", {31'd0, AddrErr}, 32'd1);
    chk("hiaddr_data", Mdatain, 32'h0);
    tick();
    chk("hiaddr_err_drop", {31'd0, AddrErr}, 32'd0);
`else
    chk("hiaddr_alias", Mdatain, 32'hFFFF_FFF4);
    tick();
`endif

    // Latency sweep: LATENCY 1, 2 and 7 launched on the same edge
    r1 = 1'b1; r7 = 1'b1; Read = 1'b1; MARaddr = 32'd5;
    tick();
    r1 = 1'b0; r7 = 1'b0; Read = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("l1_busy_k%0d", k), {31'd0, b1}, {31'd0, (k < 1)});
      chk($sformatf("l1_ready_k%0d", k), {31'd0, mr1}, {31'd0, (k == 1)});
      chk($sformatf("l2_busy_k%0d", k), {31'd0, Busy}, {31'd0, (k < 2)});
      chk($sformatf("l2_ready_k%0d", k), {31'd0, MemReady}, {31'd0, (k == 2)});
      chk($sformatf("l7_busy_k%0d", k), {31'd0, b7}, {31'd0, (k < 7)});
      chk($sformatf("l7_ready_k%0d", k), {31'd0, mr7}, {31'd0, (k == 7)});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
